// File: rtl/vector_alu_array.sv
// vector_alu_array
//   N-lane SIMD integer ALU used as the vector execute stage. Each lane
//   takes its own unsigned WIDTH-bit operand pair and 3-bit opcode. It
//   registers a 2*WIDTH-bit result one clock after the inputs are sampled.
//   Lanes share only clk and arst.
//
//   There is no handshake and no backpressure. A lane with enable[i]=1
//   accepts a new operation on every rising edge of clk. A lane with
//   enable[i]=0 holds its result, and its A/B/sel inputs are ignored.
//
// Ports
//   clk     in   1                     rising-edge clock
//   arst    in   1                     synchronous, active-high reset (clears all Z)
//   A       in   [WIDTH-1:0]   x N     operand A per lane (unsigned)
//   B       in   [WIDTH-1:0]   x N     operand B per lane (unsigned)
//   sel     in   [2:0]         x N     opcode per lane
//   enable  in   [N-1:0]               per-lane load enable
//   Z       out  [2*WIDTH-1:0] x N     registered result per lane
//
// Opcodes
//   000 ADD   001 SUB (mod 2^(2*WIDTH))   010 AND   011 OR
//   100 MUL   101 DIV (B=0 -> all ones)   110/111 reserved -> 0
module vector_alu_array #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [WIDTH-1:0]     A      [N-1:0],
    input  logic [WIDTH-1:0]     B      [N-1:0],
    input  logic [2:0]           sel    [N-1:0],
    input  logic [N-1:0]         enable,
    output logic [2*WIDTH-1:0]   Z      [N-1:0]
);

    localparam int RW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    logic [RW-1:0] z_q [N-1:0];
    logic [RW-1:0] z_d [N-1:0];

    // One lane of combinational ALU. Both operands are zero-extended to the
    // result width first. This makes ADD carry into the upper half and makes
    // SUB wrap modulo 2^RW.
    function automatic logic [RW-1:0] lane_alu(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [RW-1:0] a_ext;
        logic [RW-1:0] b_ext;
        logic [RW-1:0] r;
        a_ext = {{WIDTH{1'b0}}, a};
        b_ext = {{WIDTH{1'b0}}, b};
        r     = '0;
        case (op)
            OP_ADD: r = a_ext + b_ext;
            OP_SUB: r = a_ext - b_ext;
            OP_AND: r = a_ext & b_ext;
            OP_OR:  r = a_ext | b_ext;
            // The product of two WIDTH-bit values always fits in RW bits.
            OP_MUL: r = a_ext * b_ext;
            // A zero divisor is caught before the divider is used. The lane
            // then returns a defined all-ones value instead of X.
            OP_DIV: r = (b_ext == '0) ? {RW{1'b1}} : (a_ext / b_ext);
            default: r = '0;  // reserved opcodes 110/111
        endcase
        return r;
    endfunction

    // Next state: a disabled lane keeps its value. Its operands are never
    // consulted, so X on a disabled lane cannot reach the register.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            z_d[i] = z_q[i];
            if (enable[i]) begin
                z_d[i] = lane_alu(sel[i], A[i], B[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (arst) begin
                z_q[i] <= '0;
            end else begin
                z_q[i] <= z_d[i];
            end
        end
    end

    assign Z = z_q;

endmodule

// File: tb/tb_vector_alu_array.sv
module tb_vector_alu_array;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int RW    = 2 * WIDTH;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             arst;
    logic [WIDTH-1:0] A      [N-1:0];
    logic [WIDTH-1:0] B      [N-1:0];
    logic [2:0]       sel    [N-1:0];
    logic [N-1:0]     enable;
    logic [RW-1:0]    Z      [N-1:0];

    always #5 clk = ~clk;

    vector_alu_array #(.N(N), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .arst   (arst),
        .A      (A),
        .B      (B),
        .sel    (sel),
        .enable (enable),
        .Z      (Z)
    );

    // ---------------- scoreboard state ----------------
    int            n_pass  = 0;
    int            n_total = 0;
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] model_z [N-1:0];

    // Reference: arithmetic done in 32-bit unsigned, then truncated.
    function automatic logic [RW-1:0] ref_alu(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        int unsigned x;
        int unsigned ua;
        int unsigned ub;
        ua = 32'(a);
        ub = 32'(b);
        case (op)
            3'd0: x = ua + ub;
            3'd1: x = ua - ub;
            3'd2: x = ua & ub;
            3'd3: x = ua | ub;
            3'd4: x = ua * ub;
            3'd5: x = (ub == 0) ? 32'h0000_FFFF : ua / ub;
            default: x = 0;
        endcase
        return x[RW-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lane(input int i, input logic [2:0] s,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        sel[i] = s;
        A[i]   = a;
        B[i]   = b;
    endtask

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_lanes(input string tag, input logic [RW-1:0] e0, input logic [RW-1:0] e1,
                               input logic [RW-1:0] e2, input logic [RW-1:0] e3);
        check($sformatf("%s_l0", tag), Z[0], e0);
        check($sformatf("%s_l1", tag), Z[1], e1);
        check($sformatf("%s_l2", tag), Z[2], e2);
        check($sformatf("%s_l3", tag), Z[3], e3);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        arst   = 1'b0;
        enable = '0;
        for (int i = 0; i < N; i++) drive_lane(i, 3'd0, '0, '0);

        // Reset with everything enabled and junk operands.
        arst   = 1'b1;
        enable = '1;
        for (int i = 0; i < N; i++)
            drive_lane(i, 3'($urandom_range(0, 7)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        tick();
        check_lanes("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        arst = 1'b0;

        // Per-opcode, A=200 B=100.
        drive_lane(0, 3'b000, 8'd200, 8'd100);
        drive_lane(1, 3'b001, 8'd200, 8'd100);
        drive_lane(2, 3'b010, 8'd200, 8'd100);
        drive_lane(3, 3'b011, 8'd200, 8'd100);
        @(negedge clk);
        check("latency_before_edge", Z[0], 16'h0000);
        tick();
        check_lanes("op_add_sub_and_or", 16'h012C, 16'h0064, 16'h0040, 16'h00EC);

        drive_lane(0, 3'b100, 8'd200, 8'd100);
        drive_lane(1, 3'b101, 8'd200, 8'd100);
        drive_lane(2, 3'b110, 8'd5, 8'd3);
        drive_lane(3, 3'b111, 8'd5, 8'd3);
        tick();
        check_lanes("op_mul_div_rsv", 16'h4E20, 16'h0002, 16'h0000, 16'h0000);

        // Boundaries.
        drive_lane(0, 3'b000, 8'd255, 8'd255);
        drive_lane(1, 3'b100, 8'd255, 8'd255);
        drive_lane(2, 3'b001, 8'd0, 8'd1);
        drive_lane(3, 3'b101, 8'd7, 8'd0);
        tick();
        check_lanes("boundary_max", 16'h01FE, 16'hFE01, 16'hFFFF, 16'hFFFF);

        drive_lane(0, 3'b101, 8'd0, 8'd9);
        drive_lane(1, 3'b000, 8'd0, 8'd0);
        drive_lane(2, 3'b001, 8'd0, 8'd0);
        drive_lane(3, 3'b100, 8'd0, 8'd0);
        tick();
        check_lanes("boundary_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Reserved opcodes alongside live lanes.
        drive_lane(0, 3'b110, 8'd5, 8'd3);
        drive_lane(1, 3'b111, 8'd5, 8'd3);
        drive_lane(2, 3'b000, 8'd5, 8'd3);
        drive_lane(3, 3'b001, 8'd5, 8'd3);
        tick();
        check_lanes("reserved", 16'h0000, 16'h0000, 16'h0008, 16'h0002);

        // A=0 with random B/sel, then B=0 with random A/sel.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k < 4) drive_lane(i, 3'($urandom_range(0, 7)), 8'd0, 8'($urandom_range(0, 255)));
                else       drive_lane(i, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'd0);
                exp_q.push_back(ref_alu(sel[i], A[i], B[i]));
            end
            tick();
            for (int i = 0; i < N; i++)
                check($sformatf("zero_operand_k%0d_l%0d", k, i), Z[i], exp_q.pop_front());
        end

        // Lane independence and enable hold (X on disabled lanes).
        drive_lane(0, 3'b000, 8'd10, 8'd3);
        drive_lane(1, 3'b001, 8'd10, 8'd3);
        drive_lane(2, 3'b100, 8'd10, 8'd3);
        drive_lane(3, 3'b101, 8'd10, 8'd3);
        tick();
        check_lanes("independence", 16'd13, 16'd7, 16'd30, 16'd3);

        enable = 4'b0101;
        drive_lane(0, 3'b000, 8'd20, 8'd4);
        drive_lane(1, 3'bxxx, 8'hxx, 8'hxx);
        drive_lane(2, 3'b100, 8'd20, 8'd4);
        drive_lane(3, 3'bxxx, 8'hxx, 8'hxx);
        tick();
        check_lanes("enable_hold", 16'd24, 16'd7, 16'd80, 16'd3);

        // Mid-stream reset discards the enabled update.
        enable = '1;
        for (int i = 0; i < N; i++) drive_lane(i, 3'b000, 8'd50, 8'd60);
        arst = 1'b1;
        tick();
        check_lanes("midstream_reset", 16'h0, 16'h0, 16'h0, 16'h0);
        arst = 1'b0;
        tick();
        check_lanes("post_reset_load", 16'd110, 16'd110, 16'd110, 16'd110);

        // Random regression with hold-on-disable model.
        for (int i = 0; i < N; i++) model_z[i] = 16'd110;
        for (int c = 0; c < 1000; c++) begin
            enable = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                drive_lane(i, 3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                if (enable[i]) model_z[i] = ref_alu(sel[i], A[i], B[i]);
                exp_q.push_back(model_z[i]);
            end
            tick();
            for (int i = 0; i < N; i++)
                check($sformatf("random_c%0d_l%0d", c, i), Z[i], exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
